// File: rtl/lsu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lsu_pkg: shared types, default widths and sizing helper for the LSU |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FIN  = 2'd2
  } lsu_state_t;

  localparam int LSU_ADDR_W = 8;
  localparam int LSU_DATA_W = 8;
  localparam int LSU_REG_W  = 4;

  function automatic int lsu_cnt_w(input int timeout_cycles);
    return $clog2(timeout_cycles + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_watchdog.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lsu_watchdog: REQ-phase cycle counter, flags expiry at LIMIT-1      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module lsu_watchdog
  import lsu_pkg::*;
#(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CNT_W = lsu_cnt_w(LIMIT);

  logic [CNT_W-1:0] count;

  // Saturate at the expiry value so a stalled count never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (count_en && !expired)
      count <= count + 1'b1;
  end

  assign expired = (count == CNT_W'(LIMIT - 1));

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | load_store_unit: multi-cycle LW/SW stage with req/ack memory port   |
// | Optional REQ timeout abort when LSU_TIMEOUT_EN is defined. Rev 1.0  |
// +--------------------------------------------------------------------+
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W         = LSU_ADDR_W,
  parameter int DATA_W         = LSU_DATA_W,
  parameter int REG_W          = LSU_REG_W,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic              is_store,
  input  logic [REG_W-1:0]  reg_sel,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] store_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_en,
  output logic [REG_W-1:0]  wb_reg,
  output logic [DATA_W-1:0] wb_data
);

  lsu_state_t       state;
  lsu_state_t       next_state;
  logic             store_l;
  logic [REG_W-1:0] reg_l;
  logic             accept;
  logic             timeout;
  logic             finish_req;
  logic             load_done;

  assign accept     = (state == IDLE) && start;
  assign finish_req = (state == REQ) && (mem_ack || timeout);
  assign load_done  = finish_req && !store_l && !timeout;

`ifdef LSU_TIMEOUT_EN
  logic expired;

  lsu_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (CLK),
    .rst      (RESET),
    .clear    (accept),
    .count_en ((state == REQ) && !mem_ack),
    .expired  (expired)
  );

  // An ack in the expiry cycle takes precedence over the abort.
  assign timeout = (state == REQ) && !mem_ack && expired;
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES == 0);
  assign timeout    = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = REQ;
      REQ:     if (mem_ack || timeout) next_state = FIN;
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered from next_state so they line up with the state they describe.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wb_en     <= 1'b0;
      wb_reg    <= '0;
      wb_data   <= '0;
      store_l   <= 1'b0;
      reg_l     <= '0;
    end else begin
      busy    <= (next_state != IDLE);
      done    <= (next_state == FIN);
      err     <= timeout;
      mem_req <= (next_state == REQ);
      wb_en   <= load_done;
      if (accept) begin
        store_l   <= is_store;
        reg_l     <= reg_sel;
        mem_we    <= is_store;
        mem_addr  <= addr;
        mem_wdata <= store_data;
      end else if (next_state != REQ) begin
        mem_we <= 1'b0;
      end
      if (load_done) begin
        wb_reg  <= reg_l;
        wb_data <= mem_rdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_load_store_unit: directed self-checking bench for load_store_unit|
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_load_store_unit;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       start;
  logic       is_store;
  logic [3:0] reg_sel;
  logic [7:0] addr;
  logic [7:0] store_data;
  logic       busy;
  logic       done;
  logic       err;
  logic       mem_req;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic       wb_en;
  logic [3:0] wb_reg;
  logic [7:0] wb_data;

  int checks = 0;
  int errors = 0;

  load_store_unit #(
    .ADDR_W         (8),
    .DATA_W         (8),
    .REG_W          (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .start      (start),
    .is_store   (is_store),
    .reg_sel    (reg_sel),
    .addr       (addr),
    .store_data (store_data),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .wb_en      (wb_en),
    .wb_reg     (wb_reg),
    .wb_data    (wb_data)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic st, input logic [3:0] r, input logic [7:0] a, input logic [7:0] d);
    start      = 1'b1;
    is_store   = st;
    reg_sel    = r;
    addr       = a;
    store_data = d;
  endtask

  initial begin
    RESET = 1'b1; start = 1'b0; is_store = 1'b0; reg_sel = '0;
    addr = '0; store_data = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_wben", wb_en, 0);
    chk("rst_wbreg", wb_reg, 0);
    chk("rst_wbdata", wb_data, 0);
    RESET = 1'b0;
    tick();

    // 1: load, ack in first REQ cycle
    issue(1'b0, 4'd3, 8'h20, 8'h00);
    tick();
    start = 1'b0;
    chk("t1_busy1", busy, 1);
    chk("t1_req", mem_req, 1);
    chk("t1_we", mem_we, 0);
    chk("t1_addr", mem_addr, 8'h20);
    chk("t1_done_early", done, 0);
    mem_ack = 1'b1; mem_rdata = 8'd187;
    tick();
    mem_ack = 1'b0;
    chk("t1_done", done, 1);
    chk("t1_busy2", busy, 1);
    chk("t1_req_drop", mem_req, 0);
    chk("t1_wben", wb_en, 1);
    chk("t1_wbreg", wb_reg, 3);
    chk("t1_wbdata", wb_data, 187);
    chk("t1_err", err, 0);
    tick();
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_done", done, 0);
    chk("t1_idle_wben", wb_en, 0);
    chk("t1_hold_wbdata", wb_data, 187);

    // 2: store, ack on 4th REQ cycle
    issue(1'b1, 4'd9, 8'h05, 8'd22);
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t2_req", mem_req, 1);
      chk("t2_we", mem_we, 1);
      chk("t2_addr", mem_addr, 8'h05);
      chk("t2_wdata", mem_wdata, 22);
      chk("t2_done_early", done, 0);
      if (i == 3) mem_ack = 1'b1;
      tick();
    end
    mem_ack = 1'b0;
    chk("t2_done", done, 1);
    chk("t2_wben", wb_en, 0);
    chk("t2_req_drop", mem_req, 0);
    chk("t2_we_drop", mem_we, 0);
    chk("t2_wbreg_hold", wb_reg, 3);
    chk("t2_wbdata_hold", wb_data, 187);
    tick();

    // 3: start during REQ and FIN is dropped
    issue(1'b0, 4'd5, 8'h40, 8'h00);
    tick();
    issue(1'b1, 4'd6, 8'h99, 8'h77);
    tick();
    start = 1'b0;
    chk("t3_addr_kept", mem_addr, 8'h40);
    chk("t3_we_kept", mem_we, 0);
    mem_ack = 1'b1; mem_rdata = 8'h3C;
    tick();
    mem_ack = 1'b0;
    chk("t3_done", done, 1);
    chk("t3_wbreg", wb_reg, 5);
    chk("t3_wbdata", wb_data, 8'h3C);
    issue(1'b1, 4'd6, 8'h99, 8'h77);
    tick();
    start = 1'b0;
    chk("t3_fin_start_dropped", busy, 0);
    chk("t3_no_req", mem_req, 0);
    issue(1'b0, 4'd4, 8'h41, 8'h00);
    tick();
    start = 1'b0;
    chk("t3_new_req", mem_req, 1);
    chk("t3_new_addr", mem_addr, 8'h41);
    mem_ack = 1'b1; mem_rdata = 8'h01;
    tick();
    mem_ack = 1'b0;
    chk("t3_new_wbreg", wb_reg, 4);
    tick();

    // 4: reset mid-REQ
    issue(1'b0, 4'd7, 8'h60, 8'h00);
    tick();
    start = 1'b0;
    chk("t4_req", mem_req, 1);
    RESET = 1'b1;
    #1;
    chk("t4_async_req", mem_req, 0);
    chk("t4_async_busy", busy, 0);
    chk("t4_async_wben", wb_en, 0);
    tick();
    RESET = 1'b0;
    mem_ack = 1'b1; mem_rdata = 8'hEE;
    tick();
    mem_ack = 1'b0;
    chk("t4_no_done", done, 0);
    chk("t4_no_wben", wb_en, 0);
    chk("t4_no_req", mem_req, 0);
    issue(1'b0, 4'd2, 8'h61, 8'h00);
    tick();
    start = 1'b0;
    mem_ack = 1'b1; mem_rdata = 8'h5A;
    tick();
    mem_ack = 1'b0;
    chk("t4_wben", wb_en, 1);
    chk("t4_wbreg", wb_reg, 2);
    chk("t4_wbdata", wb_data, 8'h5A);
    tick();

    // 5: back-to-back
    issue(1'b0, 4'd1, 8'h10, 8'h00);
    tick();
    start = 1'b0;
    mem_ack = 1'b1; mem_rdata = 8'h11;
    tick();
    mem_ack = 1'b0;
    chk("t5_fin", done, 1);
    tick();
    chk("t5_idle_req", mem_req, 0);
    issue(1'b1, 4'd0, 8'h07, 8'h33);
    tick();
    start = 1'b0;
    chk("t5_req2", mem_req, 1);
    chk("t5_we2", mem_we, 1);
    chk("t5_addr2", mem_addr, 8'h07);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("t5_done2", done, 1);
    chk("t5_wben2", wb_en, 0);
    chk("t5_wbdata_hold", wb_data, 8'h11);
    tick();

`ifdef LSU_TIMEOUT_EN
    // 6a: no ack -> abort after 8 REQ cycles
    issue(1'b0, 4'd8, 8'h80, 8'h00);
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("t6_req", mem_req, 1);
      chk("t6_no_done", done, 0);
      tick();
    end
    chk("t6_done", done, 1);
    chk("t6_err", err, 1);
    chk("t6_wben", wb_en, 0);
    chk("t6_req_drop", mem_req, 0);
    tick();
    chk("t6_err_pulse", err, 0);

    // 6b: ack on 8th REQ cycle wins
    issue(1'b0, 4'd8, 8'h81, 8'h00);
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("t6b_req", mem_req, 1);
      if (i == 7) begin mem_ack = 1'b1; mem_rdata = 8'hA5; end
      tick();
    end
    mem_ack = 1'b0;
    chk("t6b_done", done, 1);
    chk("t6b_err", err, 0);
    chk("t6b_wben", wb_en, 1);
    chk("t6b_wbdata", wb_data, 8'hA5);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
